// File: rtl/factorial_top.sv
// factorial_top: single-master bus with a 32x32 RAM and a sequential 64-bit factorial core.
// Define BUS_ERROR_IRQ_EN to enable the sticky decode-error interrupt on m_interrupt.
module factorial_top (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_req,
  input  logic        M_wr,
  input  logic [7:0]  M_address,
  input  logic [31:0] M_dout,
  output logic        M_grant,
  output logic [31:0] M_din,
  output logic        f_interrupt,
  output logic        m_interrupt
);
  localparam int unsigned DW        = 32;
  localparam int unsigned RW        = 64;
  localparam int unsigned RAM_DEPTH = 32;
  localparam int unsigned RAM_AW    = 5;

  localparam logic [7:0] A_OPSTART  = 8'h20;
  localparam logic [7:0] A_OPCLEAR  = 8'h21;
  localparam logic [7:0] A_INTREN   = 8'h22;
  localparam logic [7:0] A_OPERAND  = 8'h23;
  localparam logic [7:0] A_RESULT_L = 8'h24;
  localparam logic [7:0] A_RESULT_H = 8'h25;
  localparam logic [7:0] A_STATE    = 8'h26;
  localparam logic [7:0] A_ERRCLR   = 8'h27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state, state_n;
  logic [RW-1:0] result, result_n;
  logic [DW-1:0] count, count_n;
  logic [DW-1:0] operand;
  logic          intr_en;
  logic [DW-1:0] ram [RAM_DEPTH];

  logic wr_en, rd_en, ram_sel, start, clear, busy, done;

  // Single master, bus parked on it; no grant while in reset.
  assign M_grant = M_req & reset_n;
  assign wr_en   = M_grant & M_wr;
  assign rd_en   = M_grant & ~M_wr;
  assign ram_sel = (M_address[7:5] == 3'b000);
  assign start   = wr_en & (M_address == A_OPSTART) & M_dout[0];
  assign clear   = wr_en & (M_address == A_OPCLEAR) & M_dout[0];
  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);

  // RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) ram[M_address[RAM_AW-1:0]] <= M_dout;
  end

  // Configuration registers; soft clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand <= '0;
      intr_en <= 1'b0;
    end else if (clear) begin
      operand <= '0;
      intr_en <= 1'b0;
    end else if (wr_en) begin
      if (M_address == A_OPERAND) operand <= M_dout;
      if (M_address == A_INTREN)  intr_en <= M_dout[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      result <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      result <= result_n;
      count  <= count_n;
    end
  end

  // Core next-state: operand is latched into count at start, so later writes don't disturb it.
  always_comb begin
    state_n  = state;
    result_n = result;
    count_n  = count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n  = ST_BUSY;
          result_n = RW'(1);
          count_n  = operand;
        end
      end
      ST_BUSY: begin
        if (count <= DW'(1)) begin
          state_n = ST_DONE;
        end else begin
          result_n = result * RW'(count);
          count_n  = count - DW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (clear) begin
      state_n  = ST_IDLE;
      result_n = '0;
      count_n  = '0;
    end
  end

  // Combinational read mux; write-only and unmapped locations read as zero.
  always_comb begin
    M_din = '0;
    if (rd_en) begin
      if (ram_sel) begin
        M_din = ram[M_address[RAM_AW-1:0]];
      end else begin
        case (M_address)
          A_INTREN:   M_din = DW'(intr_en);
          A_OPERAND:  M_din = operand;
          A_RESULT_L: M_din = result[DW-1:0];
          A_RESULT_H: M_din = result[RW-1:DW];
          A_STATE:    M_din = {30'b0, busy, done};
          default:    M_din = '0;
        endcase
      end
    end
  end

  assign f_interrupt = done & intr_en;

`ifdef BUS_ERROR_IRQ_EN
  logic unmapped, err;
  assign unmapped = (M_address > A_ERRCLR);

  // Sticky decode error; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                err <= 1'b0;
    else if (M_grant && unmapped)                err <= 1'b1;
    else if (wr_en && (M_address == A_ERRCLR))   err <= 1'b0;
  end
  assign m_interrupt = err;
`else
  assign m_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_factorial_top.sv
// Self-checking bench for factorial_top: directed test-plan sequence, then randomized bus traffic
// checked every cycle against a behavioural model (honours BUS_ERROR_IRQ_EN like the RTL).
module tb_factorial_top;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_req = 1'b0;
  logic        M_wr = 1'b0;
  logic [7:0]  M_address = '0;
  logic [31:0] M_dout = '0;
  logic        M_grant;
  logic [31:0] M_din;
  logic        f_interrupt;
  logic        m_interrupt;

  factorial_top dut (
    .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr),
    .M_address(M_address), .M_dout(M_dout), .M_grant(M_grant),
    .M_din(M_din), .f_interrupt(f_interrupt), .m_interrupt(m_interrupt)
  );

  always #5 clk = ~clk;

`ifdef BUS_ERROR_IRQ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Behavioural model state
  logic [31:0] m_mem [32];
  bit          m_valid [32];
  logic [31:0] m_operand;
  bit          m_en, m_busy, m_done, m_err;
  int unsigned m_n, m_t;
  logic [63:0] m_res;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_din;
  logic        last_grant, last_fint, last_mint;

  // Product n*(n-1)*...*(n-k+1), mod 2^64
  function automatic logic [63:0] partial(input int unsigned n, input int unsigned k);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < k; i++) p = p * 64'(n - i);
    return p;
  endfunction

  function automatic int unsigned mult_cycles(input int unsigned n);
    return (n > 1) ? n - 1 : 0;
  endfunction

  task automatic model_reset();
    m_operand = '0; m_en = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_n = 0; m_t = 0; m_res = '0;
    for (int i = 0; i < 32; i++) m_valid[i] = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        exp_grant;
    logic [31:0] exp_din;
    bit          din_known;
    exp_grant = reset_n & M_req;
    exp_din = '0;
    din_known = 1;
    if (exp_grant && !M_wr) begin
      if (M_address < 8'h20) begin
        din_known = m_valid[M_address[4:0]];
        exp_din = m_mem[M_address[4:0]];
      end else begin
        case (M_address)
          8'h22: exp_din = {31'b0, m_en};
          8'h23: exp_din = m_operand;
          8'h24: exp_din = m_res[31:0];
          8'h25: exp_din = m_res[63:32];
          8'h26: exp_din = {30'b0, m_busy, m_done};
          default: exp_din = '0;
        endcase
      end
    end
    chk("grant", 64'(M_grant), 64'(exp_grant));
    if (din_known) chk("din", 64'(M_din), 64'(exp_din));
    chk("f_interrupt", 64'(f_interrupt), 64'(reset_n & m_done & m_en));
    chk("m_interrupt", 64'(m_interrupt), 64'(reset_n & ERR_EN & m_err));
    last_din = M_din; last_grant = M_grant; last_fint = f_interrupt; last_mint = m_interrupt;
  endtask

  // Model update for one rising edge, from the inputs held across it
  task automatic model_step();
    bit was_busy;
    int unsigned mc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    was_busy = m_busy;
    if (m_busy) begin
      mc = mult_cycles(m_n);
      m_t++;
      m_res = partial(m_n, (m_t < mc) ? m_t : mc);
      if (m_t == mc + 1) begin m_busy = 0; m_done = 1; end
    end
    if (M_req) begin
      if (M_wr) begin
        if (M_address < 8'h20) begin
          m_mem[M_address[4:0]] = M_dout;
          m_valid[M_address[4:0]] = 1;
        end else begin
          case (M_address)
            8'h20: if (M_dout[0] && !was_busy) begin
                     m_busy = 1; m_done = 0; m_n = m_operand; m_t = 0; m_res = 64'd1;
                   end
            8'h21: if (M_dout[0]) begin
                     m_busy = 0; m_done = 0; m_res = '0; m_operand = '0; m_en = 0;
                   end
            8'h22: m_en = M_dout[0];
            8'h23: m_operand = M_dout;
            8'h27: m_err = 0;
            default: ;
          endcase
        end
      end
      if (M_address >= 8'h28) m_err = 1;
    end
  endtask

  task automatic cyc(input bit req, input bit wr, input logic [7:0] a, input logic [31:0] d);
    M_req = req; M_wr = wr; M_address = a; M_dout = d;
    #3;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Poll STATE until done; returns edges counted from the start edge inclusive
  task automatic wait_done(output int edges);
    bit ok;
    ok = 0;
    edges = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      cyc(1, 0, 8'h26, '0);
      ok = last_din[0];
      if (ok) edges = i + 1;
    end
    chk("done_timeout", 64'(ok), 64'(1));
  endtask

  initial begin
    int edges;
    bit req, wr;
    logic [7:0] a;
    logic [31:0] d;
    int unsigned r;

    model_reset();
    reset_n = 1'b0;
    cyc(1, 0, 8'h26, '0);
    chk("rst_grant", 64'(last_grant), 64'(0));
    chk("rst_din", 64'(last_din), 64'(0));
    cyc(1, 1, 8'h80, 32'hFFFF_FFFF);
    chk("rst_mint", 64'(last_mint), 64'(0));
    reset_n = 1'b1;
    cyc(1, 0, 8'h26, '0);
    chk("rst_state", 64'(last_din), 64'(0));

    for (int i = 0; i < 32; i++) cyc(1, 1, 8'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 8'(i), '0);
      chk("ram_rd", 64'(last_din), 64'(i));
      chk("ram_grant", 64'(last_grant), 64'(1));
    end

    cyc(0, 1, 8'h03, 32'hDEAD_BEEF);
    chk("noreq_grant", 64'(last_grant), 64'(0));
    cyc(0, 0, 8'h03, '0);
    chk("noreq_din", 64'(last_din), 64'(0));
    cyc(1, 0, 8'h03, '0);
    chk("noreq_ram", 64'(last_din), 64'(3));

    // N=5 with interrupt enabled
    cyc(1, 1, 8'h23, 32'd5);
    cyc(1, 1, 8'h22, 32'd1);
    cyc(1, 1, 8'h20, 32'd1);
    wait_done(edges);
    chk("lat_n5", 64'(edges), 64'(6));
    cyc(1, 0, 8'h26, '0);
    chk("n5_state", 64'(last_din), 64'(1));
    chk("n5_fint", 64'(last_fint), 64'(1));
    cyc(1, 0, 8'h24, '0);
    chk("n5_res_l", 64'(last_din), 64'(120));
    cyc(1, 0, 8'h25, '0);
    chk("n5_res_h", 64'(last_din), 64'(0));
    cyc(1, 1, 8'h21, 32'd1);
    cyc(1, 0, 8'h26, '0);
    chk("clr_state", 64'(last_din), 64'(0));
    chk("clr_fint", 64'(last_fint), 64'(0));

    // N=20, interrupt disabled by the clear
    cyc(1, 1, 8'h23, 32'd20);
    cyc(1, 1, 8'h20, 32'd1);
    wait_done(edges);
    chk("lat_n20", 64'(edges), 64'(21));
    chk("n20_fint_off", 64'(last_fint), 64'(0));
    cyc(1, 0, 8'h24, '0);
    chk("n20_res_l", 64'(last_din), 64'(32'h82B4_0000));
    cyc(1, 0, 8'h25, '0);
    chk("n20_res_h", 64'(last_din), 64'(32'h21C3_677C));

    // N=0 restarted from DONE
    cyc(1, 1, 8'h23, 32'd0);
    cyc(1, 1, 8'h20, 32'd1);
    wait_done(edges);
    chk("lat_n0", 64'(edges), 64'(2));
    cyc(1, 0, 8'h24, '0);
    chk("n0_res_l", 64'(last_din), 64'(1));
    cyc(1, 0, 8'h25, '0);
    chk("n0_res_h", 64'(last_din), 64'(0));

    // Decode error
    cyc(1, 0, 8'h80, '0);
    chk("unmapped_din", 64'(last_din), 64'(0));
    cyc(0, 0, 8'h00, '0);
    chk("mint_set", 64'(last_mint), 64'(ERR_EN));
    cyc(1, 1, 8'h27, 32'h1234);
    cyc(0, 0, 8'h00, '0);
    chk("mint_clr", 64'(last_mint), 64'(0));

    // Reset mid-computation
    cyc(1, 1, 8'h22, 32'd1);
    cyc(1, 1, 8'h23, 32'd15);
    cyc(1, 1, 8'h20, 32'd1);
    cyc(1, 0, 8'h80, '0);
    cyc(1, 0, 8'h26, '0);
    chk("pre_rst_busy", 64'(last_din), 64'(2));
    reset_n = 1'b0;
    cyc(1, 0, 8'h26, '0);
    chk("midrst_grant", 64'(last_grant), 64'(0));
    chk("midrst_din", 64'(last_din), 64'(0));
    chk("midrst_mint", 64'(last_mint), 64'(0));
    cyc(1, 0, 8'h26, '0);
    reset_n = 1'b1;
    cyc(1, 0, 8'h26, '0);
    chk("postrst_state", 64'(last_din), 64'(0));
    cyc(1, 0, 8'h23, '0);
    chk("postrst_operand", 64'(last_din), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      a = 8'($urandom_range(0, 31));
      else if (r < 92) a = 8'(8'h20 + $urandom_range(0, 7));
      else             a = 8'($urandom_range(8'h28, 8'hFF));
      case (a)
        8'h20:   d = 32'($urandom_range(0, 1));
        8'h21:   d = 32'($urandom_range(0, 15) == 0);
        8'h23:   d = 32'($urandom_range(0, 22));
        default: d = $urandom;
      endcase
      req = ($urandom_range(0, 9) != 0);
      wr = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        cyc(req, wr, a, d);
        cyc(1, 0, 8'h26, '0);
        reset_n = 1'b1;
      end else begin
        cyc(req, wr, a, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
